// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: sends pkt_count packets of pkt_len beats with an
// incrementing data pattern, TLAST on the final beat and a programmable idle gap.
// Ports: clk, reset_n (async active-low); start/stop control; pkt_len, pkt_count,
// gap_cycles, seed configuration (latched at start); M_TDATA/M_TVALID/M_TLAST/
// M_TREADY master stream; busy, done, pkts_sent, beats_sent status.
module axis_pkt_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [15:0]           pkt_count,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TVALID,
    output logic                  M_TLAST,
    input  logic                  M_TREADY,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pkts_sent,
    output logic [31:0]           beats_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           pkts_q, pkts_d;
    logic [31:0]           beats_q, beats_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic                  stop_q, stop_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [15:0]           count_q, count_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;

    logic hs;
    logic run_end;

    assign hs = valid_q && M_TREADY;

    // A stop seen in the same cycle as the last beat still ends the run here.
    assign run_end = ((count_q != 16'd0) && (pkts_q + 16'd1 == count_q))
                     || stop_q || stop;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs && last_q) begin
                    if (run_end) begin
                        state_d = IDLE;
                    end else if (gap_q == '0) begin
                        state_d = SEND;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pkts_d     = pkts_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        stop_d     = stop_q;
        len_d      = len_q;
        count_d    = count_q;
        gap_d      = gap_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                    count_d    = pkt_count;
                    gap_d      = gap_cycles;
                    data_d     = seed;
                    pkts_d     = 16'd0;
                    beats_d    = 32'd0;
                    stop_d     = 1'b0;
                    beat_cnt_d = '0;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    last_d     = (pkt_len <= LEN_WIDTH'(1));
                end
            end
            SEND: begin
                stop_d = stop_q || stop;
                if (hs) begin
                    data_d  = data_q + DATA_WIDTH'(1);
                    beats_d = beats_q + 32'd1;
                    if (last_q) begin
                        pkts_d     = pkts_q + 16'd1;
                        beat_cnt_d = '0;
                        if (run_end) begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q == '0) begin
                            last_d = (len_q == LEN_WIDTH'(1));
                        end else begin
                            valid_d   = 1'b0;
                            last_d    = 1'b0;
                            gap_cnt_d = gap_q - GAP_WIDTH'(1);
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                        last_d = (beat_cnt_q + LEN_WIDTH'(1)
                                  == len_q - LEN_WIDTH'(1));
                    end
                end
            end
            GAP: begin
                stop_d = stop_q || stop;
                if (gap_cnt_q == '0) begin
                    valid_d = 1'b1;
                    last_d  = (len_q == LEN_WIDTH'(1));
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pkts_q     <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            stop_q     <= 1'b0;
            len_q      <= LEN_WIDTH'(1);
            count_q    <= '0;
            gap_q      <= '0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pkts_q     <= pkts_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            stop_q     <= stop_d;
            len_q      <= len_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
        end
    end

    assign M_TDATA    = data_q;
    assign M_TVALID   = valid_q;
    assign M_TLAST    = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pkts_sent  = pkts_q;
    assign beats_sent = beats_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: directed runs push expected beats and
// end-of-run counters; a negedge monitor pops and compares on each event.
module tb_axis_pkt_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] pkt_len = '0;
    logic [15:0] pkt_count = '0;
    logic [7:0]  gap_cycles = '0;
    logic [31:0] seed = '0;
    logic [31:0] M_TDATA;
    logic        M_TVALID;
    logic        M_TLAST;
    logic        M_TREADY = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;
    logic [31:0] beats_sent;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [15:0] p;
        logic [31:0] b;
    } end_t;

    beat_t beat_q[$];
    end_t  end_q[$];

    always #5 clk = ~clk;

    axis_pkt_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .pkt_len    (pkt_len),
        .pkt_count  (pkt_count),
        .gap_cycles (gap_cycles),
        .seed       (seed),
        .M_TDATA    (M_TDATA),
        .M_TVALID   (M_TVALID),
        .M_TLAST    (M_TLAST),
        .M_TREADY   (M_TREADY),
        .busy       (busy),
        .done       (done),
        .pkts_sent  (pkts_sent),
        .beats_sent (beats_sent)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected beats: data seed+k, TLAST on the last beat of each packet.
    task automatic expect_run(input logic [31:0] s, input int len,
                              input int npkts);
        beat_t bt;
        end_t  et;
        for (int k = 0; k < len * npkts; k++) begin
            bt.d = s + 32'(k);
            bt.l = ((k % len) == len - 1);
            beat_q.push_back(bt);
        end
        et.p = 16'(npkts);
        et.b = 32'(len * npkts);
        end_q.push_back(et);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [15:0] len,
                            input logic [15:0] cnt, input logic [7:0] gap);
        seed = s;
        pkt_len = len;
        pkt_count = cnt;
        gap_cycles = gap;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_valid", 64'(M_TVALID), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int n, output int idle);
        n = 0;
        idle = 0;
        while (!done && n < 300) begin
            if (busy && !M_TVALID) idle++;
            tick();
            n++;
        end
        if (!done) begin
            failures++;
            $display("FAIL done_timeout: no done after %0d cycles", n);
        end
    endtask

    task automatic after_run(input logic [15:0] p, input logic [31:0] b);
        tick();
        chk("done_pulse", 64'(done), 64'd0);
        chk("pkts_hold", 64'(pkts_sent), 64'(p));
        chk("beats_hold", 64'(beats_sent), 64'(b));
    endtask

    // Monitor: scoreboard pop on handshake and run end, plus AXIS rules.
    logic        prev_stall = 1'b0;
    logic        prev_mid = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge clk) begin
        beat_t bt;
        end_t  et;
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_mid = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(M_TVALID), 64'd1);
                chk("stall_data", 64'(M_TDATA), 64'(prev_data));
                chk("stall_last", 64'(M_TLAST), 64'(prev_last));
            end
            if (prev_mid) begin
                chk("mid_pkt_valid", 64'(M_TVALID), 64'd1);
            end
            if (M_TVALID && M_TREADY) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat: got data 0x%0h, none expected",
                             M_TDATA);
                end else begin
                    bt = beat_q.pop_front();
                    chk("tdata", 64'(M_TDATA), 64'(bt.d));
                    chk("tlast", 64'(M_TLAST), 64'(bt.l));
                end
            end
            if (done) begin
                if (end_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_done: unexpected done pulse");
                end else begin
                    et = end_q.pop_front();
                    chk("done_pkts", 64'(pkts_sent), 64'(et.p));
                    chk("done_beats", 64'(beats_sent), 64'(et.b));
                    chk("done_busy", 64'(busy), 64'd0);
                    chk("done_valid", 64'(M_TVALID), 64'd0);
                end
            end
            prev_stall = M_TVALID && !M_TREADY;
            prev_mid = M_TVALID && M_TREADY && !M_TLAST;
            prev_data = M_TDATA;
            prev_last = M_TLAST;
        end
    end

    initial begin
        int n;
        int idle;
        logic [3:0] rdy;
        logic [5:0] pat;

        #2;
        chk("rst_valid", 64'(M_TVALID), 64'd0);
        chk("rst_last", 64'(M_TLAST), 64'd0);
        chk("rst_data", 64'(M_TDATA), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pkts", 64'(pkts_sent), 64'd0);
        chk("rst_beats", 64'(beats_sent), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Basic: 2 x 4 beats back-to-back from 0x100
        expect_run(32'h100, 4, 2);
        do_start(32'h100, 16'd4, 16'd2, 8'd0);
        wait_done(n, idle);
        chk("basic_cycles", 64'(n), 64'd8);
        after_run(16'd2, 32'd8);

        // Backpressure with ready pattern 1,0,0,1,0,1
        pat = 6'b101001;
        expect_run(32'h0, 3, 1);
        M_TREADY = pat[0];
        do_start(32'h0, 16'd3, 16'd1, 8'd0);
        for (int i = 1; i < 6; i++) begin
            tick();
            M_TREADY = pat[i];
        end
        tick();
        M_TREADY = 1'b1;
        chk("bp_done", 64'(done), 64'd1);
        after_run(16'd1, 32'd3);

        // Gap: 3 x 2 beats with 3 idle cycles between packets
        expect_run(32'h50, 2, 3);
        do_start(32'h50, 16'd2, 16'd3, 8'd3);
        wait_done(n, idle);
        chk("gap_cycles", 64'(n), 64'd12);
        chk("gap_idle", 64'(idle), 64'd6);
        after_run(16'd3, 32'd6);

        // Continuous run, stop during beat 2 of packet 3
        expect_run(32'h200, 5, 3);
        do_start(32'h200, 16'd5, 16'd0, 8'd0);
        for (int i = 0; i < 12; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(n, idle);
        after_run(16'd3, 32'd15);

        // pkt_len=0 behaves as single-beat packets
        expect_run(32'h77, 1, 3);
        do_start(32'h77, 16'd0, 16'd3, 8'd1);
        wait_done(n, idle);
        after_run(16'd3, 32'd3);

        // Seed wrap, with stop alongside start (stop must be ignored)
        expect_run(32'hFFFF_FFFF, 1, 2);
        stop = 1'b1;
        do_start(32'hFFFF_FFFF, 16'd1, 16'd2, 8'd0);
        stop = 1'b0;
        wait_done(n, idle);
        after_run(16'd2, 32'd2);

        // Start while busy has no effect
        expect_run(32'h300, 4, 1);
        do_start(32'h300, 16'd4, 16'd1, 8'd0);
        seed = 32'h999;
        pkt_len = 16'd1;
        pkt_count = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n, idle);
        after_run(16'd1, 32'd4);

        // Reset during beat 1, then a fresh run
        beat_q.push_back('{d: 32'h400, l: 1'b0});
        do_start(32'h400, 16'd4, 16'd1, 8'd0);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(M_TVALID), 64'd0);
        chk("mrst_last", 64'(M_TLAST), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_pkts", 64'(pkts_sent), 64'd0);
        chk("mrst_beats", 64'(beats_sent), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        expect_run(32'h500, 2, 1);
        do_start(32'h500, 16'd2, 16'd1, 8'd0);
        wait_done(n, idle);
        after_run(16'd1, 32'd2);

        rdy = 4'(beat_q.size());
        chk("beats_left", 64'(rdy), 64'd0);
        chk("ends_left", 64'(end_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
